// File: rtl/cdb_arbiter_if.sv
// Producer-side handshakes and CDB broadcast bus of the CDB arbiter.
// slave: arbiter side; master: producers and CDB consumers.
interface cdb_arbiter_if #(
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  alu_valid_in;
    logic                  alu_ready_out;
    logic [ROB_WIDTH-1:0]  alu_dest_in;
    logic [DATA_WIDTH-1:0] alu_result_in;
    logic [ADDR_WIDTH-1:0] alu_pc_in;
    logic                  alu_jump_in;

    logic                  ld_valid_in;
    logic                  ld_ready_out;
    logic [ROB_WIDTH-1:0]  ld_dest_in;
    logic [DATA_WIDTH-1:0] ld_result_in;

    logic                  st_valid_in;
    logic                  st_ready_out;
    logic [ROB_WIDTH-1:0]  st_dest_in;
    logic [DATA_WIDTH-1:0] st_result_in;

    logic                  cdb_en_out;
    logic [ROB_WIDTH-1:0]  cdb_b_out;
    logic [DATA_WIDTH-1:0] cdb_result_out;
    logic [ADDR_WIDTH-1:0] cdb_pc_out;
    logic                  cdb_jump_out;
    logic [1:0]            cdb_src_out;

    // Handshake: an entry transfers at a rising edge when valid and ready are both
    // high (and no flush); ready never depends on valid.
    modport slave (
        input  alu_valid_in, alu_dest_in, alu_result_in, alu_pc_in, alu_jump_in,
        input  ld_valid_in, ld_dest_in, ld_result_in,
        input  st_valid_in, st_dest_in, st_result_in,
        output alu_ready_out, ld_ready_out, st_ready_out,
        output cdb_en_out, cdb_b_out, cdb_result_out, cdb_pc_out, cdb_jump_out, cdb_src_out
    );

    modport master (
        output alu_valid_in, alu_dest_in, alu_result_in, alu_pc_in, alu_jump_in,
        output ld_valid_in, ld_dest_in, ld_result_in,
        output st_valid_in, st_dest_in, st_result_in,
        input  alu_ready_out, ld_ready_out, st_ready_out,
        input  cdb_en_out, cdb_b_out, cdb_result_out, cdb_pc_out, cdb_jump_out, cdb_src_out
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among ALU, load and store units,
// with a skid FIFO per source and a registered broadcast.
module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          rob_rst_in,
    cdb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [ROB_WIDTH-1:0]  dest;
        logic [DATA_WIDTH-1:0] result;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  jump;
    } entry_t;

    entry_t        mem_q [3][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q [3];
    logic [PW-1:0] wr_ptr_d [3];
    logic [PW-1:0] rd_ptr_q [3];
    logic [PW-1:0] rd_ptr_d [3];
    logic [CW-1:0] count_q  [3];
    logic [CW-1:0] count_d  [3];
    logic [1:0]    last_grant_q, last_grant_d;
    logic          cdb_en_q, cdb_en_d;
    entry_t        cdb_q, cdb_d;
    logic [1:0]    cdb_src_q, cdb_src_d;

    entry_t        in_entry [3];
    logic          in_valid [3];
    logic          ready    [3];
    logic          push     [3];
    logic          grant_valid;
    logic [1:0]    grant_src;
    logic [1:0]    cand;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        case (s)
            2'd0:    next_src = 2'd1;
            2'd1:    next_src = 2'd2;
            default: next_src = 2'd0;
        endcase
    endfunction

    always_comb begin
        in_valid[0] = bus.alu_valid_in;
        in_valid[1] = bus.ld_valid_in;
        in_valid[2] = bus.st_valid_in;
        in_entry[0] = '{dest: bus.alu_dest_in, result: bus.alu_result_in,
                        pc: bus.alu_pc_in, jump: bus.alu_jump_in};
        in_entry[1] = '{dest: bus.ld_dest_in, result: bus.ld_result_in, pc: '0, jump: 1'b0};
        in_entry[2] = '{dest: bus.st_dest_in, result: bus.st_result_in, pc: '0, jump: 1'b0};
        for (int s = 0; s < 3; s++) begin
            ready[s] = rdy_in && (count_q[s] < DEPTH_C);
        end
    end

    assign bus.alu_ready_out = ready[0];
    assign bus.ld_ready_out  = ready[1];
    assign bus.st_ready_out  = ready[2];

    // Search starts one past the last winner, so the last winner is tried last.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = last_grant_q;
        cand        = last_grant_q;
        for (int k = 0; k < 3; k++) begin
            cand = next_src(cand);
            if (!grant_valid && (count_q[cand] != '0)) begin
                grant_valid = 1'b1;
                grant_src   = cand;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        cdb_en_d     = cdb_en_q;
        cdb_d        = cdb_q;
        cdb_src_d    = cdb_src_q;
        for (int s = 0; s < 3; s++) begin
            wr_ptr_d[s] = wr_ptr_q[s];
            rd_ptr_d[s] = rd_ptr_q[s];
            count_d[s]  = count_q[s];
            push[s]     = 1'b0;
        end
        if (rdy_in && rob_rst_in) begin
            for (int s = 0; s < 3; s++) begin
                wr_ptr_d[s] = '0;
                rd_ptr_d[s] = '0;
                count_d[s]  = '0;
            end
            cdb_en_d     = 1'b0;
            last_grant_d = 2'd2;
        end else if (rdy_in) begin
            for (int s = 0; s < 3; s++) begin
                // Tag 0 names no ROB entry: the handshake completes but nothing is stored.
                push[s] = in_valid[s] && ready[s] && (in_entry[s].dest != '0);
                if (push[s]) begin
                    wr_ptr_d[s] = wr_ptr_q[s] + 1'b1;
                end
                if (grant_valid && (grant_src == 2'(s))) begin
                    rd_ptr_d[s] = rd_ptr_q[s] + 1'b1;
                    if (!push[s]) begin
                        count_d[s] = count_q[s] - 1'b1;
                    end
                end else if (push[s]) begin
                    count_d[s] = count_q[s] + 1'b1;
                end
            end
            cdb_en_d = grant_valid;
            if (grant_valid) begin
                cdb_d        = mem_q[grant_src][rd_ptr_q[grant_src]];
                cdb_src_d    = grant_src;
                last_grant_d = grant_src;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 3; s++) begin
            if (push[s]) begin
                mem_q[s][wr_ptr_q[s]] <= in_entry[s];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < 3; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
            last_grant_q <= 2'd2;
            cdb_en_q     <= 1'b0;
            cdb_q        <= '0;
            cdb_src_q    <= 2'd0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                count_q[s]  <= count_d[s];
            end
            last_grant_q <= last_grant_d;
            cdb_en_q     <= cdb_en_d;
            cdb_q        <= cdb_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign bus.cdb_en_out     = cdb_en_q;
    assign bus.cdb_b_out      = cdb_q.dest;
    assign bus.cdb_result_out = cdb_q.result;
    assign bus.cdb_pc_out     = cdb_q.pc;
    assign bus.cdb_jump_out   = cdb_q.jump;
    assign bus.cdb_src_out    = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: stimulus pushes expected broadcasts,
// a negedge monitor pops and compares every consumed CDB broadcast.
module tb_cdb_arbiter;
    localparam int RW = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int EW = 2 + RW + DW + AW + 1;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b1;
    logic rdy_in   = 1'b1;
    logic rob_rst_in = 1'b0;

    cdb_arbiter_if #(.ROB_WIDTH(RW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cdb_arbiter #(.ROB_WIDTH(RW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .rdy_in     (rdy_in),
        .rob_rst_in (rob_rst_in),
        .bus        (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] bc(input logic [1:0] src, input logic [RW-1:0] tag,
                                         input logic [DW-1:0] res, input logic [AW-1:0] pc,
                                         input logic jmp);
        return {src, tag, res, pc, jmp};
    endfunction

    // A broadcast is consumed at the next rising edge when rdy_in is high.
    always @(negedge clk_in) begin
        if (rst_n_in && rdy_in && bus.cdb_en_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_bcast: got src %0d tag %0d result %0h, required none",
                         bus.cdb_src_out, bus.cdb_b_out, bus.cdb_result_out);
            end else begin
                check("bcast", {bus.cdb_src_out, bus.cdb_b_out, bus.cdb_result_out,
                                bus.cdb_pc_out, bus.cdb_jump_out}, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid_in  = 1'b0;
        bus.alu_dest_in   = '0;
        bus.alu_result_in = '0;
        bus.alu_pc_in     = '0;
        bus.alu_jump_in   = 1'b0;
        bus.ld_valid_in   = 1'b0;
        bus.ld_dest_in    = '0;
        bus.ld_result_in  = '0;
        bus.st_valid_in   = 1'b0;
        bus.st_dest_in    = '0;
        bus.st_result_in  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy_in     = 1'b1;
        rob_rst_in = 1'b0;
        rst_n_in   = 1'b0;
        repeat (2) step();
        rst_n_in   = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_en"},     bus.cdb_en_out,     0);
        check({tag, "_b"},      bus.cdb_b_out,      0);
        check({tag, "_result"}, bus.cdb_result_out, 0);
        check({tag, "_pc"},     bus.cdb_pc_out,     0);
        check({tag, "_jump"},   bus.cdb_jump_out,   0);
        check({tag, "_src"},    bus.cdb_src_out,    0);
    endtask

    // Each source offers entries until n of them have been accepted; data carries
    // the per-source acceptance index so lost or reordered entries are visible.
    task automatic run_traffic(input int n_a, input int n_l, input int n_s, input int cycles,
                               input logic [RW-1:0] tag_a, input logic [RW-1:0] tag_l,
                               input logic [RW-1:0] tag_s, input bit inc,
                               input int chk_a, input logic [2:0] rdy_a,
                               input int chk_b, input logic [2:0] rdy_b);
        int acc[3];
        logic [2:0] vld;
        logic [2:0] rdy;
        acc = '{0, 0, 0};
        for (int cyc = 0; cyc < cycles; cyc++) begin
            vld = {acc[2] < n_s, acc[1] < n_l, acc[0] < n_a};
            bus.alu_valid_in  = vld[0];
            bus.alu_dest_in   = tag_a + (inc ? RW'(acc[0]) : RW'(0));
            bus.alu_result_in = 32'hA000 + 32'(acc[0]);
            bus.alu_pc_in     = 32'h200 + 32'(acc[0]);
            bus.alu_jump_in   = acc[0][0];
            bus.ld_valid_in   = vld[1];
            bus.ld_dest_in    = tag_l + (inc ? RW'(acc[1]) : RW'(0));
            bus.ld_result_in  = 32'hB000 + 32'(acc[1]);
            bus.st_valid_in   = vld[2];
            bus.st_dest_in    = tag_s + (inc ? RW'(acc[2]) : RW'(0));
            bus.st_result_in  = 32'hC000 + 32'(acc[2]);
            @(negedge clk_in);
            rdy = {bus.st_ready_out, bus.ld_ready_out, bus.alu_ready_out};
            if (cyc == chk_a) check($sformatf("ready_cyc%0d", cyc), rdy, rdy_a);
            if (cyc == chk_b) check($sformatf("ready_cyc%0d", cyc), rdy, rdy_b);
            step();
            for (int s = 0; s < 3; s++) begin
                if (vld[s] && rdy[s]) acc[s]++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        // Reset state, and ready following rdy_in while empty
        #2 rst_n_in = 1'b0;
        #1;
        check_outputs_zero("rst");
        check("rst_alu_rdy", bus.alu_ready_out, 1);
        check("rst_ld_rdy",  bus.ld_ready_out,  1);
        check("rst_st_rdy",  bus.st_ready_out,  1);
        rdy_in = 1'b0;
        #1;
        check("rst_rdy0_ready", {bus.st_ready_out, bus.ld_ready_out, bus.alu_ready_out}, 3'b000);
        rdy_in = 1'b1;
        step();
        rst_n_in = 1'b1;
        step();

        // Single ALU result
        exp_q.push_back(bc(2'd0, 4'd3, 32'h1234, 32'h100, 1'b1));
        bus.alu_valid_in  = 1'b1;
        bus.alu_dest_in   = 4'd3;
        bus.alu_result_in = 32'h1234;
        bus.alu_pc_in     = 32'h100;
        bus.alu_jump_in   = 1'b1;
        step();
        idle_inputs();
        step();
        check("t1_en_e1", bus.cdb_en_out, 1);
        step();
        check("t1_en_e2", bus.cdb_en_out, 0);
        check("t1_hold_b", bus.cdb_b_out, 3);

        // All three sources continuously valid after reset
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(bc(2'd0, 4'd1, 32'hA000 + 32'(k), 32'h200 + 32'(k), k[0]));
            exp_q.push_back(bc(2'd1, 4'd2, 32'hB000 + 32'(k), 32'h0, 1'b0));
            exp_q.push_back(bc(2'd2, 4'd3, 32'hC000 + 32'(k), 32'h0, 1'b0));
        end
        run_traffic(3, 3, 3, 14, 4'd1, 4'd2, 4'd3, 1'b0, 2, 3'b001, 3, 3'b010);
        check("t2_drain", exp_q.size(), 0);

        // Four loads back to back against a busy ALU
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(bc(2'd0, 4'd8 + 4'(k), 32'hA000 + 32'(k), 32'h200 + 32'(k), k[0]));
            exp_q.push_back(bc(2'd1, 4'd4 + 4'(k), 32'hB000 + 32'(k), 32'h0, 1'b0));
        end
        run_traffic(4, 4, 0, 14, 4'd8, 4'd4, 4'd1, 1'b1, 2, 3'b101, 3, 3'b110);
        check("t3_drain", exp_q.size(), 0);

        // Freeze with a live broadcast; a flush and a new entry offered while frozen
        exp_q.push_back(bc(2'd0, 4'd5, 32'h55, 32'h300, 1'b0));
        exp_q.push_back(bc(2'd1, 4'd6, 32'h66, 32'h0, 1'b0));
        bus.alu_valid_in  = 1'b1;
        bus.alu_dest_in   = 4'd5;
        bus.alu_result_in = 32'h55;
        bus.alu_pc_in     = 32'h300;
        bus.ld_valid_in   = 1'b1;
        bus.ld_dest_in    = 4'd6;
        bus.ld_result_in  = 32'h66;
        step();
        idle_inputs();
        step();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                rob_rst_in        = 1'b1;
                bus.alu_valid_in  = 1'b1;
                bus.alu_dest_in   = 4'd7;
                bus.alu_result_in = 32'h77;
            end else begin
                rob_rst_in = 1'b0;
                idle_inputs();
            end
            @(negedge clk_in);
            check($sformatf("t4_frz_en%0d", i), bus.cdb_en_out, 1);
            check($sformatf("t4_frz_b%0d", i), bus.cdb_b_out, 5);
            check($sformatf("t4_frz_rdy%0d", i),
                  {bus.st_ready_out, bus.ld_ready_out, bus.alu_ready_out}, 3'b000);
            step();
        end
        rob_rst_in = 1'b0;
        idle_inputs();
        rdy_in = 1'b1;
        step();
        step();
        @(negedge clk_in);
        check("t4_idle_en", bus.cdb_en_out, 0);
        check("t4_drain", exp_q.size(), 0);
        step();

        // Flush with entries queued and a same-edge ALU offer
        exp_q.push_back(bc(2'd2, 4'd14, 32'h9200, 32'h0, 1'b0));
        for (int k = 0; k < 2; k++) begin
            bus.alu_valid_in  = 1'b1;
            bus.alu_dest_in   = 4'd9 + 4'(k);
            bus.alu_result_in = 32'h9000 + 32'(k);
            bus.alu_pc_in     = 32'h400 + 32'(k);
            bus.alu_jump_in   = 1'b1;
            bus.ld_valid_in   = 1'b1;
            bus.ld_dest_in    = 4'd12 + 4'(k);
            bus.ld_result_in  = 32'h9100 + 32'(k);
            bus.st_valid_in   = 1'b1;
            bus.st_dest_in    = 4'd14 + 4'(k);
            bus.st_result_in  = 32'h9200 + 32'(k);
            step();
        end
        idle_inputs();
        rob_rst_in        = 1'b1;
        bus.alu_valid_in  = 1'b1;
        bus.alu_dest_in   = 4'd7;
        bus.alu_result_in = 32'h7777;
        step();
        rob_rst_in = 1'b0;
        idle_inputs();
        @(negedge clk_in);
        check("t5_flush_en", bus.cdb_en_out, 0);
        check("t5_flush_rdy", {bus.st_ready_out, bus.ld_ready_out, bus.alu_ready_out}, 3'b111);
        step();
        exp_q.push_back(bc(2'd0, 4'd1, 32'hA000, 32'h200, 1'b0));
        exp_q.push_back(bc(2'd1, 4'd2, 32'hB000, 32'h0, 1'b0));
        exp_q.push_back(bc(2'd2, 4'd3, 32'hC000, 32'h0, 1'b0));
        run_traffic(1, 1, 1, 6, 4'd1, 4'd2, 4'd3, 1'b0, -1, 3'b000, -1, 3'b000);
        check("t5_drain", exp_q.size(), 0);

        // Store with tag 0: handshake completes, nothing broadcast
        bus.st_valid_in  = 1'b1;
        bus.st_dest_in   = 4'd0;
        bus.st_result_in = 32'hDEAD;
        @(negedge clk_in);
        check("t6_st_rdy", bus.st_ready_out, 1);
        step();
        idle_inputs();
        step();
        check("t6_en_e1", bus.cdb_en_out, 0);
        step();
        check("t6_en_e2", bus.cdb_en_out, 0);

        // Asynchronous reset mid-cycle with a broadcast live and a load pending
        bus.alu_valid_in  = 1'b1;
        bus.alu_dest_in   = 4'd9;
        bus.alu_result_in = 32'h77;
        bus.alu_pc_in     = 32'h500;
        bus.alu_jump_in   = 1'b1;
        bus.ld_valid_in   = 1'b1;
        bus.ld_dest_in    = 4'd10;
        bus.ld_result_in  = 32'h88;
        step();
        idle_inputs();
        @(posedge clk_in);
        #1;
        check("t7_pre_en", bus.cdb_en_out, 1);
        #2 rst_n_in = 1'b0;
        #1;
        check_outputs_zero("t7_arst");
        check("t7_arst_rdy", {bus.st_ready_out, bus.ld_ready_out, bus.alu_ready_out}, 3'b111);
        step();
        rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t7_post_en%0d", i), bus.cdb_en_out, 0);
        end

        check("final_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
